// File: rtl/mipi_rx_frame_ctrl_if.sv
// mipi_rx_frame_ctrl_if: configuration, D-PHY packet and status bundle for the frame capture sequencer
//   master (host/D-PHY side) drives: cfg_en, cfg_continuous, cfg_dt, cfg_lines, err_clr,
//                                     sp_en, lp_av_en, dt, wc, payload_en
//   slave (sequencer) drives:         ref_dt, tx_rdy, cap_en, frame_start, frame_end, line_start,
//                                     line_end, line_cnt, frame_cnt, busy, err_wc, err_lines, err_seq
interface mipi_rx_frame_ctrl_if #(
  parameter int LINE_CNT_W  = 12,
  parameter int FRAME_CNT_W = 16
);
  logic                   cfg_en;
  logic                   cfg_continuous;
  logic [5:0]             cfg_dt;
  logic [LINE_CNT_W-1:0]  cfg_lines;
  logic                   err_clr;
  logic                   sp_en;
  logic                   lp_av_en;
  logic [5:0]             dt;
  logic [15:0]            wc;
  logic                   payload_en;
  logic [5:0]             ref_dt;
  logic                   tx_rdy;
  logic                   cap_en;
  logic                   frame_start;
  logic                   frame_end;
  logic                   line_start;
  logic                   line_end;
  logic [LINE_CNT_W-1:0]  line_cnt;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic                   busy;
  logic                   err_wc;
  logic                   err_lines;
  logic                   err_seq;
  modport master (
    output cfg_en, cfg_continuous, cfg_dt, cfg_lines, err_clr, sp_en, lp_av_en, dt, wc, payload_en,
    input  ref_dt, tx_rdy, cap_en, frame_start, frame_end, line_start, line_end, line_cnt, frame_cnt,
           busy, err_wc, err_lines, err_seq
  );
  modport slave (
    input  cfg_en, cfg_continuous, cfg_dt, cfg_lines, err_clr, sp_en, lp_av_en, dt, wc, payload_en,
    output ref_dt, tx_rdy, cap_en, frame_start, frame_end, line_start, line_end, line_cnt, frame_cnt,
           busy, err_wc, err_lines, err_seq
  );
endinterface

// File: rtl/mipi_rx_frame_ctrl.sv
// mipi_rx_frame_ctrl: byte-clock capture sequencer gating the D-PHY receive path to whole video frames
//   byte_clk     : the only clock
//   byte_clk_rst : synchronous active-high reset
//   bus          : slave side of mipi_rx_frame_ctrl_if (config, packet strobes in; status, counters, errors out)
module mipi_rx_frame_ctrl #(
  parameter int NUM_RX_LANE = 2,
  parameter int RX_GEAR     = 8,
  parameter int LINE_CNT_W  = 12,
  parameter int FRAME_CNT_W = 16
) (
  input logic                 byte_clk,
  input logic                 byte_clk_rst,
  mipi_rx_frame_ctrl_if.slave bus
);
  localparam int BPC = NUM_RX_LANE * RX_GEAR / 8;
  localparam logic [1:0] IDLE = 2'd0, WAIT_FS = 2'd1, FRAME = 2'd2, LINE = 2'd3;
  logic [1:0]             state_q, state_d;
  logic [LINE_CNT_W-1:0]  line_q, line_d;
  logic [FRAME_CNT_W-1:0] frame_q, frame_d;
  logic [15:0]            pcnt_q, pcnt_d, pcnt_inc, wc_q, wc_d;
  logic [16:0]            exp_words;
  logic [5:0]             ref_dt_q;
  logic                   done_q, done_d;
  logic                   fs_q, fs_d, fe_q, fe_d, ls_q, ls_d, le_q, le_d;
  logic                   err_wc_q, err_lines_q, err_seq_q, set_wc, set_lines, set_seq;
  logic                   fs, fe, vl, any_pkt, close, frame_pkt;
  assign fs        = bus.sp_en && bus.dt == 6'h00;
  assign fe        = bus.sp_en && bus.dt == 6'h01;
  assign vl        = bus.lp_av_en && bus.dt == bus.cfg_dt;
  assign any_pkt   = bus.sp_en || bus.lp_av_en;
  assign exp_words = ({1'b0, wc_q} + 17'(BPC - 1)) / 17'(BPC);
  assign pcnt_inc  = (bus.payload_en && !(&pcnt_q)) ? pcnt_q + 16'd1 : pcnt_q;
  // A line closes on the first idle cycle after payload, or early on any packet header
  // (which also covers zero-length lines that never see payload).
  assign close     = state_q == LINE && ((!bus.payload_en && pcnt_q != '0) || any_pkt);
  // A header that closes a line is then treated exactly as if it arrived in FRAME.
  assign frame_pkt = state_q == FRAME || close;
  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    frame_d   = frame_q;
    pcnt_d    = state_q == LINE ? pcnt_inc : pcnt_q;
    wc_d      = wc_q;
    done_d    = done_q && bus.cfg_en;
    fs_d      = 1'b0;
    fe_d      = 1'b0;
    ls_d      = 1'b0;
    le_d      = close;
    set_wc    = close && {1'b0, pcnt_inc} != exp_words;
    set_seq   = (state_q == LINE && any_pkt) || (state_q == WAIT_FS && fe);
    set_lines = 1'b0;
    if (state_q == IDLE)
      state_d = (bus.cfg_en && !done_q) ? WAIT_FS : IDLE;
    if (state_q == WAIT_FS) begin
      state_d = fs ? FRAME : bus.cfg_en ? WAIT_FS : IDLE;
      fs_d    = fs;
      line_d  = fs ? '0 : line_q;
    end
    if (close) begin
      state_d = FRAME;
      line_d  = (&line_q) ? line_q : line_q + LINE_CNT_W'(1);
    end
    if (frame_pkt && vl) begin
      state_d = LINE;
      wc_d    = bus.wc;
      pcnt_d  = '0;
      ls_d    = 1'b1;
    end else if (frame_pkt && fe) begin
      state_d   = (bus.cfg_en && bus.cfg_continuous) ? WAIT_FS : IDLE;
      frame_d   = frame_q + FRAME_CNT_W'(1);
      fe_d      = 1'b1;
      set_lines = bus.cfg_lines != '0 && line_d != bus.cfg_lines;
      // Single-shot holds off re-arming until cfg_en is dropped.
      done_d    = !(bus.cfg_en && bus.cfg_continuous);
    end else if (frame_pkt && fs) begin
      state_d = FRAME;
      line_d  = '0;
      fs_d    = 1'b1;
      set_seq = 1'b1;
    end
  end
  always_ff @(posedge byte_clk) begin
    if (byte_clk_rst) begin
      state_q     <= IDLE;
      line_q      <= '0;
      frame_q     <= '0;
      pcnt_q      <= '0;
      wc_q        <= '0;
      ref_dt_q    <= '0;
      done_q      <= 1'b0;
      fs_q        <= 1'b0;
      fe_q        <= 1'b0;
      ls_q        <= 1'b0;
      le_q        <= 1'b0;
      err_wc_q    <= 1'b0;
      err_lines_q <= 1'b0;
      err_seq_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      frame_q     <= frame_d;
      pcnt_q      <= pcnt_d;
      wc_q        <= wc_d;
      ref_dt_q    <= bus.cfg_dt;
      done_q      <= done_d;
      fs_q        <= fs_d;
      fe_q        <= fe_d;
      ls_q        <= ls_d;
      le_q        <= le_d;
      err_wc_q    <= set_wc || (err_wc_q && !bus.err_clr);
      err_lines_q <= set_lines || (err_lines_q && !bus.err_clr);
      err_seq_q   <= set_seq || (err_seq_q && !bus.err_clr);
    end
  end
  assign bus.ref_dt      = ref_dt_q;
  assign bus.tx_rdy      = state_q != IDLE;
  assign bus.busy        = state_q != IDLE;
  assign bus.cap_en      = state_q == FRAME || state_q == LINE;
  assign bus.frame_start = fs_q;
  assign bus.frame_end   = fe_q;
  assign bus.line_start  = ls_q;
  assign bus.line_end    = le_q;
  assign bus.line_cnt    = line_q;
  assign bus.frame_cnt   = frame_q;
  assign bus.err_wc      = err_wc_q;
  assign bus.err_lines   = err_lines_q;
  assign bus.err_seq     = err_seq_q;
endmodule

// File: tb/tb_mipi_rx_frame_ctrl.sv
// tb_mipi_rx_frame_ctrl: scenario and randomized frame checks of mipi_rx_frame_ctrl against a frame-level model
module tb_mipi_rx_frame_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0, bad = 0, exp_frames = 0;
  int n_fs = 0, n_fe = 0, n_ls = 0, n_le = 0;
  mipi_rx_frame_ctrl_if bus ();
  mipi_rx_frame_ctrl dut (.byte_clk(clk), .byte_clk_rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    n_fs = n_fs + int'(bus.frame_start);
    n_fe = n_fe + int'(bus.frame_end);
    n_ls = n_ls + int'(bus.line_start);
    n_le = n_le + int'(bus.line_end);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send_sp(input logic [5:0] d);
    bus.sp_en = 1'b1;
    bus.dt = d;
    step();
    bus.sp_en = 1'b0;
  endtask
  task automatic send_lp(input logic [5:0] d, input logic [15:0] w);
    bus.lp_av_en = 1'b1;
    bus.dt = d;
    bus.wc = w;
    step();
    bus.lp_av_en = 1'b0;
  endtask
  task automatic send_payload(input int n);
    if (n > 0) begin
      bus.payload_en = 1'b1;
      repeat (n) step();
      bus.payload_en = 1'b0;
      step();
    end
  endtask
  task automatic clear_errs();
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
  endtask
  task automatic test_reset();
    bus.cfg_en = 1'b1; bus.cfg_continuous = 1'b1; bus.cfg_dt = 6'h2B; bus.cfg_lines = 12'd4;
    bus.err_clr = 1'b0; bus.sp_en = 1'b0; bus.lp_av_en = 1'b0; bus.dt = 6'h00; bus.wc = 16'd0; bus.payload_en = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    total++; if ({bus.cap_en, bus.busy, bus.tx_rdy, bus.frame_start, bus.frame_end, bus.line_start, bus.line_end} !== 7'd0)
      begin bad++; $display("FAIL reset_flags: got %b want 0", {bus.cap_en, bus.busy, bus.tx_rdy, bus.frame_start, bus.frame_end, bus.line_start, bus.line_end}); end
    total++; if ({bus.err_wc, bus.err_lines, bus.err_seq} !== 3'd0) begin bad++; $display("FAIL reset_errs: got %b want 000", {bus.err_wc, bus.err_lines, bus.err_seq}); end
    total++; if (bus.line_cnt !== 12'd0 || bus.frame_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnts: got %0d/%0d want 0/0", bus.line_cnt, bus.frame_cnt); end
    total++; if (bus.ref_dt !== 6'h00) begin bad++; $display("FAIL reset_ref_dt: got %0h want 0", bus.ref_dt); end
    rst = 1'b0;
    exp_frames = 0;
    step();
    total++; if ({bus.busy, bus.tx_rdy, bus.cap_en} !== 3'b110) begin bad++; $display("FAIL arm: got %b want 110", {bus.busy, bus.tx_rdy, bus.cap_en}); end
    total++; if (bus.ref_dt !== 6'h2B) begin bad++; $display("FAIL ref_dt: got %0h want 2b", bus.ref_dt); end
  endtask
  task automatic test_basic_frame();
    int s_le = n_le;
    send_sp(6'h00);
    total++; if (bus.frame_start !== 1'b1 || bus.cap_en !== 1'b1) begin bad++; $display("FAIL basic_fs: got fs=%b cap=%b want 1/1", bus.frame_start, bus.cap_en); end
    for (int l = 0; l < 4; l++) begin
      send_lp(6'h2B, 16'd10);
      if (l == 0) begin
        total++; if (bus.line_start !== 1'b1) begin bad++; $display("FAIL basic_ls: got %b want 1", bus.line_start); end
      end
      send_payload(5);
      if (l == 0) begin
        total++; if (bus.line_end !== 1'b1 || bus.line_cnt !== 12'd1) begin bad++; $display("FAIL basic_le: got le=%b cnt=%0d want 1/1", bus.line_end, bus.line_cnt); end
      end
    end
    send_sp(6'h01);
    exp_frames++;
    total++; if (bus.frame_end !== 1'b1 || bus.cap_en !== 1'b0 || bus.busy !== 1'b1) begin bad++; $display("FAIL basic_fe: got fe=%b cap=%b busy=%b want 1/0/1", bus.frame_end, bus.cap_en, bus.busy); end
    step();
    total++; if (n_le - s_le !== 4) begin bad++; $display("FAIL basic_le_count: got %0d want 4", n_le - s_le); end
    total++; if (bus.line_cnt !== 12'd4 || bus.frame_cnt !== 16'(exp_frames)) begin bad++; $display("FAIL basic_cnts: got %0d/%0d want 4/%0d", bus.line_cnt, bus.frame_cnt, exp_frames); end
    total++; if ({bus.err_wc, bus.err_lines, bus.err_seq} !== 3'd0) begin bad++; $display("FAIL basic_errs: got %b want 000", {bus.err_wc, bus.err_lines, bus.err_seq}); end
  endtask
  task automatic test_wc_err();
    bus.cfg_lines = 12'd0;
    send_sp(6'h00);
    send_lp(6'h2B, 16'd11);
    bus.payload_en = 1'b1;
    repeat (5) step();
    bus.payload_en = 1'b0;
    total++; if (bus.err_wc !== 1'b0) begin bad++; $display("FAIL wc_early: got %b want 0", bus.err_wc); end
    step();
    total++; if (bus.err_wc !== 1'b1 || bus.line_end !== 1'b1) begin bad++; $display("FAIL wc_err: got err=%b le=%b want 1/1", bus.err_wc, bus.line_end); end
    send_sp(6'h01);
    exp_frames++;
    clear_errs();
    total++; if (bus.err_wc !== 1'b0) begin bad++; $display("FAIL wc_clr: got %b want 0", bus.err_wc); end
  endtask
  task automatic test_lines_err();
    bus.cfg_lines = 12'd4;
    send_sp(6'h00);
    for (int l = 0; l < 3; l++) begin
      send_lp(6'h2B, 16'd4);
      send_payload(2);
    end
    total++; if (bus.err_lines !== 1'b0) begin bad++; $display("FAIL lines_early: got %b want 0", bus.err_lines); end
    send_sp(6'h01);
    exp_frames++;
    total++; if (bus.err_lines !== 1'b1 || bus.line_cnt !== 12'd3) begin bad++; $display("FAIL lines_err: got err=%b cnt=%0d want 1/3", bus.err_lines, bus.line_cnt); end
    clear_errs();
    bus.cfg_lines = 12'd0;
  endtask
  task automatic test_seq();
    send_sp(6'h01);
    total++; if (bus.err_seq !== 1'b1 || bus.cap_en !== 1'b0 || bus.busy !== 1'b1) begin bad++; $display("FAIL seq_fe_wait: got err=%b cap=%b busy=%b want 1/0/1", bus.err_seq, bus.cap_en, bus.busy); end
    clear_errs();
    send_sp(6'h00);
    send_lp(6'h2B, 16'd6);
    send_payload(3);
    total++; if (bus.line_cnt !== 12'd1 || bus.err_seq !== 1'b0) begin bad++; $display("FAIL seq_pre: got cnt=%0d err=%b want 1/0", bus.line_cnt, bus.err_seq); end
    send_sp(6'h00);
    total++; if (bus.err_seq !== 1'b1 || bus.frame_start !== 1'b1 || bus.line_cnt !== 12'd0 || bus.cap_en !== 1'b1)
      begin bad++; $display("FAIL seq_fs_frame: got err=%b fs=%b cnt=%0d cap=%b want 1/1/0/1", bus.err_seq, bus.frame_start, bus.line_cnt, bus.cap_en); end
    send_sp(6'h01);
    exp_frames++;
    clear_errs();
  endtask
  task automatic test_random_frames();
    int nl, w, need, n, s_fs, s_fe, s_ls, s_le;
    logic ewc, eseq, elines;
    for (int f = 0; f < 15; f++) begin
      bus.cfg_dt = 6'($urandom_range(24, 63));
      nl = int'($urandom_range(0, 5));
      case ($urandom_range(0, 2))
        0: bus.cfg_lines = 12'd0;
        1: bus.cfg_lines = 12'(nl);
        default: bus.cfg_lines = 12'(nl + 1);
      endcase
      elines = bus.cfg_lines != 12'd0 && nl != int'(bus.cfg_lines);
      ewc = 1'b0;
      eseq = 1'b0;
      clear_errs();
      s_fs = n_fs; s_fe = n_fe; s_ls = n_ls; s_le = n_le;
      send_sp(6'h00);
      if ($urandom_range(0, 1) == 1) send_lp(bus.cfg_dt ^ 6'h01, 16'd8);
      for (int l = 0; l < nl; l++) begin
        w = int'($urandom_range(0, 40));
        need = (w + 1) / 2;
        n = need;
        if ($urandom_range(0, 3) == 0) n = (need > 0 && $urandom_range(0, 1) == 1) ? need - 1 : need + 1;
        ewc = ewc | (n != need);
        eseq = eseq | (n == 0);
        send_lp(bus.cfg_dt, 16'(w));
        repeat ($urandom_range(0, 2)) step();
        send_payload(n);
        if (n > 0) begin
          repeat ($urandom_range(0, 2)) step();
          if ($urandom_range(0, 3) == 0) send_sp(6'h12);
        end
      end
      send_sp(6'h01);
      exp_frames++;
      step();
      total++; if (n_fs - s_fs !== 1 || n_fe - s_fe !== 1) begin bad++; $display("FAIL rnd%0d_frame_pulses: got fs=%0d fe=%0d want 1/1", f, n_fs - s_fs, n_fe - s_fe); end
      total++; if (n_ls - s_ls !== nl || n_le - s_le !== nl) begin bad++; $display("FAIL rnd%0d_line_pulses: got ls=%0d le=%0d want %0d", f, n_ls - s_ls, n_le - s_le, nl); end
      total++; if (bus.line_cnt !== 12'(nl) || bus.frame_cnt !== 16'(exp_frames)) begin bad++; $display("FAIL rnd%0d_cnts: got %0d/%0d want %0d/%0d", f, bus.line_cnt, bus.frame_cnt, nl, exp_frames); end
      total++; if ({bus.err_wc, bus.err_lines, bus.err_seq} !== {ewc, elines, eseq}) begin bad++; $display("FAIL rnd%0d_errs: got %b want %b", f, {bus.err_wc, bus.err_lines, bus.err_seq}, {ewc, elines, eseq}); end
      total++; if (bus.cap_en !== 1'b0 || bus.busy !== 1'b1) begin bad++; $display("FAIL rnd%0d_state: got cap=%b busy=%b want 0/1", f, bus.cap_en, bus.busy); end
    end
    bus.cfg_dt = 6'h2B;
    bus.cfg_lines = 12'd0;
    clear_errs();
  endtask
  task automatic test_single_shot();
    bus.cfg_continuous = 1'b0;
    for (int fr = 0; fr < 2; fr++) begin
      send_sp(6'h00);
      if (fr == 1) begin
        total++; if (bus.cap_en !== 1'b0 || bus.frame_start !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL single_second: got cap=%b fs=%b busy=%b want 0/0/0", bus.cap_en, bus.frame_start, bus.busy); end
      end
      send_lp(6'h2B, 16'd4);
      send_payload(2);
      send_sp(6'h01);
      if (fr == 0) exp_frames++;
      step();
      total++; if (bus.busy !== 1'b0 || bus.cap_en !== 1'b0 || bus.frame_cnt !== 16'(exp_frames)) begin bad++; $display("FAIL single_f%0d: got busy=%b cap=%b cnt=%0d want 0/0/%0d", fr, bus.busy, bus.cap_en, bus.frame_cnt, exp_frames); end
    end
    bus.cfg_en = 1'b0;
    step();
    bus.cfg_en = 1'b1;
    step();
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL single_rearm: got %b want 1", bus.busy); end
    bus.cfg_continuous = 1'b1;
  endtask
  task automatic test_reset_mid();
    int s_fe, s_ls, s_le;
    send_sp(6'h00);
    send_lp(6'h2B, 16'd6);
    send_payload(3);
    send_lp(6'h2B, 16'd6);
    bus.payload_en = 1'b1;
    step();
    step();
    s_fe = n_fe;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.payload_en = 1'b0;
    exp_frames = 0;
    total++; if ({bus.cap_en, bus.busy, bus.tx_rdy, bus.frame_end, bus.line_end} !== 5'd0 || bus.line_cnt !== 12'd0 || bus.frame_cnt !== 16'd0)
      begin bad++; $display("FAIL midrst_outs: got flags=%b line=%0d frame=%0d want 0", {bus.cap_en, bus.busy, bus.tx_rdy, bus.frame_end, bus.line_end}, bus.line_cnt, bus.frame_cnt); end
    step();
    total++; if (n_fe !== s_fe) begin bad++; $display("FAIL midrst_no_fe: got %0d want 0", n_fe - s_fe); end
    s_ls = n_ls; s_le = n_le;
    send_sp(6'h00);
    send_lp(6'h2C, 16'd6);
    send_payload(3);
    send_lp(6'h2A, 16'd2);
    send_payload(1);
    send_sp(6'h01);
    exp_frames++;
    step();
    total++; if (n_ls - s_ls !== 0 || n_le - s_le !== 0) begin bad++; $display("FAIL other_dt_pulses: got ls=%0d le=%0d want 0/0", n_ls - s_ls, n_le - s_le); end
    total++; if (bus.line_cnt !== 12'd0 || bus.frame_cnt !== 16'(exp_frames)) begin bad++; $display("FAIL other_dt_cnts: got %0d/%0d want 0/%0d", bus.line_cnt, bus.frame_cnt, exp_frames); end
  endtask
  initial begin
    test_reset();
    test_basic_frame();
    test_wc_err();
    test_lines_err();
    test_seq();
    test_random_frames();
    test_single_shot();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mipi_rx_frame_ctrl.md
# mipi_rx_frame_ctrl

Capture sequencer for the 2-lane soft D-PHY receive path, running in the byte-clock domain between the D-PHY packet outputs and the byte-to-pixel converter. It arms the receiver and programs its reference data type. It tracks frame-start, frame-end and video long-packet boundaries, and gates capture to whole frames. It also counts lines and frames and raises sticky errors for word-count, line-count and packet-sequence violations.

## Interface
- NUM_RX_LANE, 2, lanes; bytes per payload cycle BPC = NUM_RX_LANE*RX_GEAR/8
- RX_GEAR, 8, bits per lane per byte_clk
- LINE_CNT_W, 12, line counter width
- FRAME_CNT_W, 16, frame counter width

Ports:
- byte_clk  in  1  byte clock; the only clock
- byte_clk_rst  in  1  reset, synchronous, active-high
- cfg_en  in  1  capture enable (level)
- cfg_continuous  in  1  1 = capture every frame; 0 = capture one frame, then go idle
- cfg_dt  in  6  accepted video data type
- cfg_lines  in  LINE_CNT_W  expected lines per frame; 0 = no check
- err_clr  in  1  single-cycle clear of all sticky errors
- sp_en  in  1  short-packet strobe; dt valid in the same cycle
- lp_av_en  in  1  video long-packet header strobe; dt and wc valid in the same cycle
- dt  in  6  packet data type
- wc  in  16  long-packet word count in bytes
- payload_en  in  1  payload valid; contiguous for one long packet
- ref_dt  out  6  registered cfg_dt, to D-PHY
- tx_rdy  out  1  receiver ready, to D-PHY
- cap_en  out  1  frame capture window
- frame_start, frame_end, line_start, line_end  out  1 each  single-cycle pulses
- line_cnt  out  LINE_CNT_W  lines in the current or last frame
- frame_cnt  out  FRAME_CNT_W  completed frames; wraps
- busy  out  1  state is not IDLE
- err_wc, err_lines, err_seq  out  1 each  sticky errors

## Operation
- States: IDLE, WAIT_FS, FRAME, LINE.
- FS = sp_en && dt==6'h00. FE = sp_en && dt==6'h01. VL = lp_av_en && dt==cfg_dt. Other packets are ignored.
- IDLE → WAIT_FS when cfg_en=1.
- WAIT_FS:
  - FS → FRAME; clear line_cnt.
  - cfg_en=0 → IDLE.
  - FE → err_seq; stay in WAIT_FS.
- FRAME:
  - VL → LINE; latch wc; clear the payload cycle counter.
  - FE → frame end (see below).
  - FS → err_seq; restart the frame: clear line_cnt, pulse frame_start, stay in FRAME.
- LINE:
  - Count cycles with payload_en=1 (16-bit counter, saturating).
  - The line ends on the first payload_en=0 cycle after at least one payload_en=1 cycle. On line end: line_cnt+1 (saturating), return to FRAME.
  - Word-count check at line end: err_wc if count != ceil(wc/BPC), i.e. (wc+BPC-1)/BPC in 17-bit arithmetic. For wc=0 the expected count is 0; the line ends on the next sp_en or VL.
  - sp_en or lp_av_en in LINE → err_seq; close the line as above in that cycle; the packet is then handled as if in FRAME, on the same cycle.
- Frame end:
  - frame_cnt+1.
  - err_lines if cfg_lines!=0 and line_cnt!=cfg_lines.
  - Next state is WAIT_FS if cfg_en && cfg_continuous, else IDLE.
- cfg_en=0 in FRAME or LINE does not abort; the current frame completes.
- Sticky errors: set has priority over err_clr in the same cycle.
- tx_rdy = 1 in WAIT_FS, FRAME and LINE.
- ref_dt = cfg_dt, sampled every cycle.

## Timing
- All outputs are registered. Reset (byte_clk_rst=1 at an edge) sets:
  - state IDLE
  - all outputs 0, including both counters and all errors
  - ref_dt=0
- Reset mid-frame drops the frame; no frame_end pulse is issued.
- frame_start pulse and cap_en rise occur one cycle after the FS input cycle.
- frame_end pulse and cap_en fall occur one cycle after the FE input cycle.
- line_start pulse occurs one cycle after VL.
- line_end pulse, the line_cnt update and err_wc occur one cycle after the first low payload_en cycle.
- busy and tx_rdy change one cycle after the state transition input.
- frame_cnt wraps from all-ones to 0. line_cnt saturates at all-ones.

## Test plan
- Continuous mode, cfg_dt=6'h2B, cfg_lines=4, BPC=2. Stimulus: FS, 4 × (VL wc=10 + 5 payload cycles), FE. Required: 4 line_end pulses, line_cnt=4, frame_cnt=1, no errors, state back in WAIT_FS.
- wc=11 with 5 payload cycles → err_wc=1 one cycle after payload ends. Then err_clr → err_wc=0.
- Single-shot mode, two frames sent → only the first is captured: cap_en low during the second, frame_cnt=1, busy=0.
- cfg_lines=4 with 3 lines sent → err_lines=1 one cycle after FE.
- FE in WAIT_FS → err_seq=1, cap_en stays 0. FS while in FRAME → err_seq=1, frame_start pulse, line_cnt=0.
- Reset asserted during line 2 → all outputs 0, state IDLE, no frame_end. Packets with dt≠cfg_dt in FRAME → no line pulses.
